unshuffle_reader: RTL and testbench
===================================

Name: unshuffle_reader

Overview:
- Read-side counterpart of the group-A image loader.
- Reads a 28x28 8-bit image that was stored pixel-unshuffled across the four group-A SRAM banks.
- Re-serializes it into a raster-order pixel stream with a valid/ready handshake.
- Used for debug readback and for feeding raster-order consumers after the image has been loaded.

Parameters:
- CH_NUM, 4, channels per SRAM word
- ACT_PER_ADDR, 4, activations per channel per word
- BW_PER_ACT, 8, bits per pixel
- IMG_DIM, 28, image width and height; must be a multiple of 4 and at most 32

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to read the whole image
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the final pixel handshake
- n_sram_cen  out  4  per-bank read enable, active low, one bit per bank 0..3
- n_sram_raddr_a  out  6  read address shared by all banks
- sram_rdata_a0..a3  in  CH_NUM*ACT_PER_ADDR*BW_PER_ACT each  read data of banks 0..3, valid 1 cycle after the enable
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts a pixel
- out_data  out  BW_PER_ACT  pixel value
- out_last  out  1  marks pixel (IMG_DIM-1, IMG_DIM-1)

Behaviour:
- Clock and reset: one clock; rst_n is asynchronous and active-low.
- Reset values: all outputs 0 except n_sram_cen=4'b1111. Internal counters, buffers and FSM are cleared.
- Pixel (r,c) location:
  - group g = c/4, k = c%4
  - bank = {r[2], g[0]}
  - addr = 6*r[4:3] + g[2:1]
  - byte position p = 4*ch + 2*dy + dx, with ch = 2*r[0] + c[0], dy = r[1], dx = c[1]
  - p=0 is the MSB byte: bits [127-8p -: 8]
- Traversal: rows 0..27; per row, groups 0..6; per group, k=0..3. One SRAM read per group, 196 reads total. Exactly one n_sram_cen bit is low during a read.
- FSM states:
  - IDLE: start moves to RUN.
  - RUN: issues reads.
  - DRAIN: after the last read, until the final pixel handshake.
  - DONE: one cycle; done=1; returns to IDLE.
- Buffering: two 4-pixel slots, cur and nxt, plus at most one read in flight.
  - A read is issued in a cycle when groups remain, no read is in flight, and nxt is empty or will be vacated this cycle.
  - Read data is extracted into nxt on the return cycle.
  - nxt moves to cur when cur is empty or its 4th pixel handshakes.
- Throughput: with out_ready=1 continuously, output is 1 pixel per cycle with no bubbles after the first.
- Latency: start sampled at edge 0, first read at cycle 1, first out_valid at cycle 3.
- Handshake: a transfer occurs when out_valid && out_ready. While out_valid=1 and out_ready=0, out_data and out_last are held stable. out_valid never drops without a transfer.
- out_last is high only with pixel 783. done pulses the cycle after that transfer. busy falls together with done.
- Start is ignored while busy.
- Reset mid-operation aborts immediately. The next start reads from pixel 0.

Test Plan:
1. SRAM model preloaded by loader convention; start, out_ready=1 -> 784 pixels in raster order, first valid at cycle 3, last at cycle 786 with out_last=1, done at cycle 787, 196 reads observed.
2. Pixel (13,21) unique value -> read of bank 3, addr 8; out_data taken from bits [31:24]; it appears as stream index 385.
3. out_ready random at 30% -> same 784-value sequence; out_data stable while stalled; never more than one read in flight.
4. out_ready held low 50 cycles after the first valid -> exactly 2 reads issued (cur+nxt full), then n_sram_cen=4'b1111 until ready returns.
5. start pulsed again mid-run -> ignored; stream and read count unchanged.
6. rst_n asserted at pixel 300, released, start -> outputs reset immediately; new stream begins at pixel 0 with full 784 count.

Source files
------------

// File: rtl/unshuffle_reader.sv
// unshuffle_reader: reads a pixel-unshuffled image back out of the four
// group-A SRAM banks. It streams the pixels in raster order over a
// valid/ready handshake. One SRAM word holds one 4-pixel column group.
// Two 4-pixel slots (cur, nxt) plus a single outstanding read are enough
// to sustain one pixel per cycle.
module unshuffle_reader #(
    parameter int CH_NUM       = 4,
    parameter int ACT_PER_ADDR = 4,
    parameter int BW_PER_ACT   = 8,
    parameter int IMG_DIM      = 28
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    output logic                                      busy,
    output logic                                      done,
    output logic [3:0]                                n_sram_cen,
    output logic [5:0]                                n_sram_raddr_a,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_rdata_a0,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_rdata_a1,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_rdata_a2,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_rdata_a3,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [BW_PER_ACT-1:0]                     out_data,
    output logic                                      out_last
);

    localparam int         WORD_W   = CH_NUM * ACT_PER_ADDR * BW_PER_ACT;
    localparam int         GRP_NUM  = IMG_DIM / 4;
    localparam logic [4:0] LAST_ROW = 5'(IMG_DIM - 1);
    localparam logic [2:0] LAST_GRP = 3'(GRP_NUM - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                         r_state;
    logic                           r_busy;
    logic                           r_done;
    logic [3:0]                     r_cen;
    logic [5:0]                     r_addr;
    // next group to be read
    logic [4:0]                     r_row;
    logic [2:0]                     r_grp;
    logic                           r_issued_all;
    // read pipeline: pend = enable cycle, ret = data-return cycle
    logic                           r_pend;
    logic [1:0]                     r_pend_bank;
    logic [1:0]                     r_pend_rlo;
    logic                           r_pend_last;
    logic                           r_ret;
    logic [1:0]                     r_ret_bank;
    logic [1:0]                     r_ret_rlo;
    logic                           r_ret_last;
    // pixel slots
    logic                           r_cur_valid;
    logic [3:0][BW_PER_ACT-1:0]     r_cur_pix;
    logic [1:0]                     r_cur_k;
    logic                           r_cur_last;
    logic                           r_nxt_valid;
    logic [3:0][BW_PER_ACT-1:0]     r_nxt_pix;
    logic                           r_nxt_last;

    logic                           w_hs;
    logic                           w_cur_vacate;
    logic                           w_cur_free;
    logic                           w_nxt_move;
    logic                           w_ret_to_cur;
    logic                           w_nxt_busy_after;
    logic                           w_can_run;
    logic                           w_issue;
    logic                           w_last_grp;
    logic                           w_final_hs;
    logic [1:0]                     w_bank;
    logic [5:0]                     w_addr;
    logic [WORD_W-1:0]              w_word;
    logic [3:0][BW_PER_ACT-1:0]     w_ext;

    assign out_valid      = r_cur_valid;
    assign out_data       = r_cur_pix[r_cur_k];
    assign out_last       = r_cur_valid & r_cur_last & (r_cur_k == 2'd3);
    assign busy           = r_busy;
    assign done           = r_done;
    assign n_sram_cen     = r_cen;
    assign n_sram_raddr_a = r_addr;

    assign w_hs         = r_cur_valid & out_ready;
    assign w_cur_vacate = w_hs & (r_cur_k == 2'd3);
    assign w_cur_free   = ~r_cur_valid | w_cur_vacate;
    assign w_nxt_move   = r_nxt_valid & w_cur_free;
    // returning data bypasses nxt when the stream would otherwise starve
    assign w_ret_to_cur = r_ret & w_cur_free & ~r_nxt_valid;
    // nxt occupancy after this edge decides whether a new read fits
    assign w_nxt_busy_after = (r_nxt_valid & ~w_nxt_move) | (r_ret & ~w_ret_to_cur);
    assign w_can_run  = (r_state == S_RUN) | ((r_state == S_IDLE) & start);
    assign w_issue    = w_can_run & ~r_issued_all & ~r_pend & ~w_nxt_busy_after;
    assign w_last_grp = (r_row == LAST_ROW) & (r_grp == LAST_GRP);
    assign w_final_hs = w_hs & out_last;
    assign w_bank     = {r_row[2], r_grp[0]};
    assign w_addr     = 6'(r_row[4:3]) * 6'd6 + 6'(r_grp[2:1]);

    // select the bank whose read is returning this cycle
    always_comb begin
        w_word = sram_rdata_a0;
        unique case (r_ret_bank)
            2'd0: w_word = sram_rdata_a0;
            2'd1: w_word = sram_rdata_a1;
            2'd2: w_word = sram_rdata_a2;
            2'd3: w_word = sram_rdata_a3;
        endcase
    end

    // byte position for column offset k: p = {r[0], c[0], r[1], c[1]}, p=0 is MSB
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ext
            localparam logic GI_C0 = 1'(gi % 2);
            localparam logic GI_C1 = 1'(gi / 2);
            logic [3:0]        w_pos;
            logic [WORD_W-1:0] w_shift;
            assign w_pos     = {r_ret_rlo[0], GI_C0, r_ret_rlo[1], GI_C1};
            assign w_shift   = w_word << (BW_PER_ACT * w_pos);
            assign w_ext[gi] = w_shift[WORD_W-1 -: BW_PER_ACT];
        end
    endgenerate

    // control FSM with registered busy/done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: if (start) begin
                    r_state <= S_RUN;
                    r_busy  <= 1'b1;
                end
                S_RUN: if (w_issue && w_last_grp) r_state <= S_DRAIN;
                S_DRAIN: if (w_final_hs) begin
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                S_DONE: r_state <= S_IDLE;
            endcase
        end
    end

    // read issue: bank enable, address and group counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cen        <= 4'b1111;
            r_addr       <= '0;
            r_row        <= '0;
            r_grp        <= '0;
            r_issued_all <= 1'b0;
        end else begin
            r_cen <= 4'b1111;
            if (w_issue) begin
                r_cen  <= ~(4'b0001 << w_bank);
                r_addr <= w_addr;
                if (w_last_grp) begin
                    r_row        <= '0;
                    r_grp        <= '0;
                    r_issued_all <= 1'b1;
                end else if (r_grp == LAST_GRP) begin
                    r_grp <= '0;
                    r_row <= r_row + 5'd1;
                end else begin
                    r_grp <= r_grp + 3'd1;
                end
            end else if (r_state == S_DONE) begin
                r_issued_all <= 1'b0;
            end
        end
    end

    // track the single outstanding read and what its data belongs to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend      <= 1'b0;
            r_pend_bank <= '0;
            r_pend_rlo  <= '0;
            r_pend_last <= 1'b0;
            r_ret       <= 1'b0;
            r_ret_bank  <= '0;
            r_ret_rlo   <= '0;
            r_ret_last  <= 1'b0;
        end else begin
            r_pend      <= w_issue;
            r_pend_bank <= w_bank;
            r_pend_rlo  <= r_row[1:0];
            r_pend_last <= w_last_grp;
            r_ret       <= r_pend;
            r_ret_bank  <= r_pend_bank;
            r_ret_rlo   <= r_pend_rlo;
            r_ret_last  <= r_pend_last;
        end
    end

    // cur slot: the group currently being streamed out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_valid <= 1'b0;
            r_cur_pix   <= '0;
            r_cur_k     <= '0;
            r_cur_last  <= 1'b0;
        end else if (w_nxt_move) begin
            r_cur_valid <= 1'b1;
            r_cur_pix   <= r_nxt_pix;
            r_cur_k     <= '0;
            r_cur_last  <= r_nxt_last;
        end else if (w_ret_to_cur) begin
            r_cur_valid <= 1'b1;
            r_cur_pix   <= w_ext;
            r_cur_k     <= '0;
            r_cur_last  <= r_ret_last;
        end else if (w_cur_vacate) begin
            r_cur_valid <= 1'b0;
            r_cur_k     <= '0;
        end else if (w_hs) begin
            r_cur_k <= r_cur_k + 2'd1;
        end
    end

    // nxt slot: prefetched group waiting for cur to drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nxt_valid <= 1'b0;
            r_nxt_pix   <= '0;
            r_nxt_last  <= 1'b0;
        end else if (r_ret && !w_ret_to_cur) begin
            r_nxt_valid <= 1'b1;
            r_nxt_pix   <= w_ext;
            r_nxt_last  <= r_ret_last;
        end else if (w_nxt_move) begin
            r_nxt_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_unshuffle_reader.sv
// Bench for unshuffle_reader: SRAM model preloaded with an unshuffled image,
// expected pixels and per-run expectations queued by the stimulus, and a
// negedge monitor that owns all comparisons.
module tb_unshuffle_reader;

    localparam int DIM = 28;
    localparam int NPIX = DIM * DIM;

    localparam int K_RESET   = 0;
    localparam int K_READS   = 1;
    localparam int K_STALLED = 2;
    localparam int K_IDLE    = 3;
    localparam int K_TIMEOUT = 4;
    localparam int K_DRAINED = 5;

    typedef struct {int kind; int val; int exp;} req_t;
    typedef struct {int npix; int reads; int first; int lastc; int donec;} run_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         busy, done, out_valid, out_ready, out_last;
    logic [3:0]   n_sram_cen;
    logic [5:0]   n_sram_raddr_a;
    logic [127:0] rd0 = '0, rd1 = '0, rd2 = '0, rd3 = '0;
    logic [7:0]   out_data;

    logic [7:0]   img [DIM][DIM];
    logic [7:0]   sbytes [4][64][16];

    int   mode = 0;             // 0: ready high, 1: ready low, 2: random
    int   n_err = 0, n_chk = 0;
    int   pix_q[$];
    run_t run_q[$];
    req_t req_q[$];

    // monitor-owned run state
    bit   run_active = 0;
    int   run_cyc = 0, run_pix = 0, run_reads = 0, run_first = -1, run_lastc = -1;
    bit   saw_b3a8 = 0;
    bit   prev_stall = 0, prev_read = 0, prev_last = 0;
    logic [7:0] prev_data = '0;

    unshuffle_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .n_sram_cen(n_sram_cen), .n_sram_raddr_a(n_sram_raddr_a),
        .sram_rdata_a0(rd0), .sram_rdata_a1(rd1),
        .sram_rdata_a2(rd2), .sram_rdata_a3(rd3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] word_of(input int b, input logic [5:0] a);
        logic [127:0] w = '0;
        for (int p = 0; p < 16; p++) w = {w[119:0], sbytes[b][a][p]};
        return w;
    endfunction

    // SRAM banks: data valid the cycle after the enable
    always @(posedge clk) begin
        if (!n_sram_cen[0]) rd0 <= word_of(0, n_sram_raddr_a);
        if (!n_sram_cen[1]) rd1 <= word_of(1, n_sram_raddr_a);
        if (!n_sram_cen[2]) rd2 <= word_of(2, n_sram_raddr_a);
        if (!n_sram_cen[3]) rd3 <= word_of(3, n_sram_raddr_a);
    end

    // consumer ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 99) < 30);
            endcase
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s got=%0d (0x%0h) want=%0d (0x%0h) run_cyc=%0d pix=%0d",
                     name, got, got, want, want, run_cyc, run_pix);
        end
    endtask

    // monitor: evaluates queued probes, stream pixels and per-run figures
    always @(negedge clk) begin
        while (req_q.size() > 0) begin
            req_t r;
            r = req_q.pop_front();
            case (r.kind)
                K_RESET: begin
                    chk("rst_busy_done", {busy, done}, 0);
                    chk("rst_cen", n_sram_cen, 15);
                    chk("rst_addr", n_sram_raddr_a, 0);
                    chk("rst_out", {out_valid, out_last, out_data}, 0);
                end
                K_READS:   chk("reads_so_far", run_reads, r.exp);
                K_STALLED: chk("stall_state", {busy, out_valid, n_sram_cen}, {2'b11, 4'hF});
                K_IDLE:    chk("idle_state", {busy, out_valid, n_sram_cen}, {2'b00, 4'hF});
                K_TIMEOUT: chk("wait_bound", r.val, r.exp);
                K_DRAINED: chk("queues_empty", pix_q.size() + run_q.size(), 0);
                default: ;
            endcase
        end
        if (!rst_n) begin
            pix_q.delete();
            run_q.delete();
            run_active = 0;
            prev_stall = 0;
            prev_read  = 0;
        end else begin
            if (run_active) run_cyc++;
            if (start && !busy && !done) begin
                run_active = 1; run_cyc = 0; run_pix = 0; run_reads = 0;
                run_first = -1; run_lastc = -1; saw_b3a8 = 0;
            end
            if (prev_stall)
                chk("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_last, prev_data});
            prev_stall = out_valid && !out_ready;
            prev_last  = out_last;
            prev_data  = out_data;
            if (n_sram_cen != 4'hF) begin
                chk("onehot_cen", int'($onehot(~n_sram_cen)), 1);
                chk("one_in_flight", int'(prev_read), 0);
                run_reads++;
                if (n_sram_cen == 4'b0111 && n_sram_raddr_a == 6'd8) saw_b3a8 = 1;
            end
            prev_read = (n_sram_cen != 4'hF);
            if (out_valid && run_first < 0) run_first = run_cyc;
            if (out_valid && out_ready) begin
                if (pix_q.size() == 0) begin
                    chk("extra_pixel", {out_last, out_data}, -1);
                end else begin
                    chk("pixel", {out_last, out_data}, pix_q.pop_front());
                end
                if (run_pix == 385) chk("px13_21_b3a8", {saw_b3a8, out_data}, {1'b1, 8'hA5});
                if (out_last) run_lastc = run_cyc;
                run_pix++;
            end
            if (done) begin
                chk("busy_at_done", busy, 0);
                if (run_q.size() == 0) begin
                    chk("unexpected_done", run_cyc, -1);
                end else begin
                    run_t e;
                    e = run_q.pop_front();
                    chk("run_npix", run_pix, e.npix);
                    chk("run_reads", run_reads, e.reads);
                    if (e.first >= 0) chk("first_valid_cyc", run_first, e.first);
                    if (e.lastc >= 0) chk("last_cyc", run_lastc, e.lastc);
                    if (e.donec >= 0) chk("done_cyc", run_cyc, e.donec);
                end
                run_active = 0;
            end
        end
    end

    task automatic push_req(input int kind, input int val, input int exp);
        req_t r;
        r.kind = kind; r.val = val; r.exp = exp;
        req_q.push_back(r);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // queue the expected stream (and optionally the run figures), then start
    task automatic start_run(input bit with_run, input int first, input int lastc, input int donec);
        run_t e;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                pix_q.push_back({(r == DIM - 1 && c == DIM - 1) ? 1'b1 : 1'b0, img[r][c]});
        if (with_run) begin
            e.npix = NPIX; e.reads = NPIX / 4; e.first = first; e.lastc = lastc; e.donec = donec;
            run_q.push_back(e);
        end
        pulse_start();
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!done && n < limit) begin @(negedge clk); n++; end
        if (!done) push_req(K_TIMEOUT, int'(done), 1);
    endtask

    initial begin
        // image with a unique marker at (13,21); stored with the loader mapping
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                int g, bank, addr, p;
                logic [7:0] v;
                v = 8'((r * 37 + c * 11 + r * c * 3 + 1) & 255);
                if (v == 8'hA5) v = 8'h5A;
                if (r == 13 && c == 21) v = 8'hA5;
                img[r][c] = v;
                g = c / 4;
                bank = (((r >> 2) & 1) << 1) | (g & 1);
                addr = 6 * ((r >> 3) & 3) + ((g >> 1) & 3);
                p = 4 * (2 * (r & 1) + (c & 1)) + 2 * ((r >> 1) & 1) + ((c >> 1) & 1);
                sbytes[bank][addr][p] = v;
            end
        end

        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        push_req(K_RESET, 0, 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;

        // full run with ready held high: latency and throughput
        mode = 0;
        start_run(1, 3, 786, 787);
        wait_done(2000);

        // random backpressure
        mode = 2;
        start_run(1, -1, -1, -1);
        wait_done(20000);

        // long stall right after the first valid pixel
        mode = 1;
        start_run(1, 3, -1, -1);
        begin
            int n = 0;
            while (!out_valid && n < 20) begin @(negedge clk); n++; end
            if (!out_valid) push_req(K_TIMEOUT, int'(out_valid), 1);
        end
        repeat (50) @(negedge clk);
        push_req(K_READS, 0, 2);
        push_req(K_STALLED, 0, 0);
        @(negedge clk);
        mode = 0;
        wait_done(2000);

        // second start mid-run is ignored
        mode = 0;
        start_run(1, 3, 786, 787);
        repeat (200) @(negedge clk);
        pulse_start();
        wait_done(2000);
        repeat (10) @(negedge clk);
        push_req(K_IDLE, 0, 0);

        // reset mid-stream, then a clean full run
        start_run(0, -1, -1, -1);
        begin
            int n = 0;
            while (run_pix < 300 && n < 2000) begin @(negedge clk); n++; end
            if (run_pix < 300) push_req(K_TIMEOUT, run_pix, 300);
        end
        @(posedge clk); #1 rst_n = 1'b0;
        push_req(K_RESET, 0, 0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        start_run(1, 3, 786, 787);
        wait_done(2000);

        repeat (5) @(negedge clk);
        push_req(K_DRAINED, 0, 0);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
